// File: rtl/pipeline_if.sv
// pipeline_if -- instruction-fetch stage with PC register and IF/ID register.
// Next-PC priority: exception vectors, then stall hold, then the branch, jump
// and jr redirects from ID, then sequential PC+4.
// Every output comes from a flop, so there is no combinational path from
// Instr_in to any output.
// Optional feature: define IF_PERF_CNT_EN to add the FetchCnt output. FetchCnt
// counts the edges that load a real instruction into IF/ID.
module pipeline_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [2:0]  PCSrc,
  input  logic        IDcontrol_Branch,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] PCout,
  input  logic [31:0] Instr_in,
  output logic [31:0] Inst_addr,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instruction,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] FetchCnt,
`endif
  output logic        Flush
);

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_plus4;
  logic        exc_s;
  logic        taken_s;
  logic        redirect_s;
  logic        load_s;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
`endif

  // Classify this cycle's ID control.
  // The bit-31 privilege flag is kept out of the sequential increment.
  always_comb begin
    pc_plus4   = {pc_q[31], pc_q[30:0] + 31'd4};
    exc_s      = (PCSrc == 3'd4) || (PCSrc == 3'd5);
    taken_s    = (PCSrc == 3'd1) && IDcontrol_Branch;
    redirect_s = taken_s || (PCSrc == 3'd2) || (PCSrc == 3'd3);
    load_s     = !exc_s && !Stall && !redirect_s;
  end

  // Select the next PC.
  // Exceptions beat a stall. A stall only defers a redirect; ID keeps
  // presenting that redirect, so it is taken once the stall drops.
  always_comb begin
    pc_d = pc_plus4;
    if (PCSrc == 3'd4) begin
      pc_d = ILLOP_PC;
    end else if (PCSrc == 3'd5) begin
      pc_d = XADR_PC;
    end else if (Stall) begin
      pc_d = pc_q;
    end else begin
      case (PCSrc)
        3'd1:    pc_d = IDcontrol_Branch ? ConBA : pc_plus4;
        3'd2:    pc_d = {pc_plus4[31:28], JT, 2'b00};
        // A user-mode jr cannot set the kernel bit.
        3'd3:    pc_d = {pc_q[31] & PCout[31], PCout[30:0]};
        default: pc_d = pc_plus4;
      endcase
    end
  end

  // IF/ID next state: insert a bubble on a redirect, hold on a stall,
  // otherwise capture the fetched word.
  always_comb begin
    id_pc_d    = pc_plus4;
    id_instr_d = Instr_in;
    flush_d    = 1'b0;
    if (exc_s || (!Stall && redirect_s)) begin
      id_pc_d    = 32'h0000_0000;
      id_instr_d = 32'h0000_0000;
      flush_d    = 1'b1;
    end else if (Stall) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      flush_d    = 1'b0;
    end else begin
      id_pc_d    = pc_plus4;
      id_instr_d = Instr_in;
      flush_d    = 1'b0;
    end
  end

  // Update the PC and the IF/ID state. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= 32'h0000_0000;
      flush_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      flush_q    <= flush_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Next count: add one per real instruction loaded into IF/ID; wraps naturally.
  always_comb begin
    if (load_s) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
  end

  // Fetch-count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign FetchCnt = fetch_cnt_q;
`else
  // load_s only feeds the optional counter.
  logic unused_load_s;
  assign unused_load_s = load_s;
`endif

  assign Inst_addr      = pc_q;
  assign ID_PC          = id_pc_q;
  assign ID_instruction = id_instr_q;
  assign Flush          = flush_q;

endmodule

// File: tb/tb_pipeline_if.sv
// tb_pipeline_if -- directed test of pipeline_if. Every expected value is
// worked out by hand. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
`timescale 1ns/1ps
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic [2:0]  PCSrc;
  logic        IDcontrol_Branch;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] PCout;
  logic [31:0] Instr_in;
  logic [31:0] Inst_addr;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic        Flush;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] I0 = 32'h2008_0001;
  localparam logic [31:0] I1 = 32'h1111_1111;

  pipeline_if dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .PCSrc(PCSrc),
    .IDcontrol_Branch(IDcontrol_Branch),
    .ConBA(ConBA),
    .JT(JT),
    .PCout(PCout),
    .Instr_in(Instr_in),
    .Inst_addr(Inst_addr),
    .ID_PC(ID_PC),
    .ID_instruction(ID_instruction),
`ifdef IF_PERF_CNT_EN
    .FetchCnt(FetchCnt),
`endif
    .Flush(Flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] idpc,
                         input logic [31:0] idins, input logic fl);
    chk({tag, ".addr"},  Inst_addr,      addr);
    chk({tag, ".idpc"},  ID_PC,          idpc);
    chk({tag, ".idins"}, ID_instruction, idins);
    chk({tag, ".flush"}, {31'd0, Flush}, {31'd0, fl});
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; PCSrc = 3'd0; IDcontrol_Branch = 1'b0;
    ConBA = 32'h0; JT = 26'h0; PCout = 32'h0; Instr_in = I0;

    // reset state
    step();
    chk_all("reset", 32'h8000_0000, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("cnt_reset", FetchCnt, 32'd0);
`endif

    // free-running fetch
    reset = 1'b0;
    step(); chk_all("seq1", 32'h8000_0004, 32'h8000_0004, I0, 1'b0);
    step(); chk_all("seq2", 32'h8000_0008, 32'h8000_0008, I0, 1'b0);

    // taken branch, then recovery; flush lasts one cycle
    PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h8000_0040;
    step(); chk_all("br_taken", 32'h8000_0040, 32'h0, 32'h0, 1'b1);
    PCSrc = 3'd0; IDcontrol_Branch = 1'b0;
    step(); chk_all("br_after", 32'h8000_0044, 32'h8000_0044, I0, 1'b0);

    // not-taken branch
    PCSrc = 3'd1; IDcontrol_Branch = 1'b0;
    step(); chk_all("br_nt", 32'h8000_0048, 32'h8000_0048, I0, 1'b0);

    // stall with a jump pending, for 2 cycles
    Stall = 1'b1; PCSrc = 3'd2; JT = 26'h000_0010; Instr_in = I1;
    step(); chk_all("stall1", 32'h8000_0048, 32'h8000_0048, I0, 1'b0);
    step(); chk_all("stall2", 32'h8000_0048, 32'h8000_0048, I0, 1'b0);
    Stall = 1'b0;
    step(); chk_all("jump", 32'h8000_0040, 32'h0, 32'h0, 1'b1);
    PCSrc = 3'd0;
    step(); chk_all("jump_after", 32'h8000_0044, 32'h8000_0044, I1, 1'b0);

    // exceptions override stall
    Stall = 1'b1; PCSrc = 3'd4;
    step(); chk_all("illop", 32'h8000_0004, 32'h0, 32'h0, 1'b1);
    Stall = 1'b0; PCSrc = 3'd5;
    step(); chk_all("xadr", 32'h8000_0008, 32'h0, 32'h0, 1'b1);
    PCSrc = 3'd0;
    step(); chk_all("exc_after", 32'h8000_000C, 32'h8000_000C, I1, 1'b0);

    // jr: kernel to user; a user-mode jr cannot reach kernel space
    PCSrc = 3'd3; PCout = 32'h0000_0100;
    step(); chk("jr_to_user", Inst_addr, 32'h0000_0100);
    PCout = 32'h8000_1000;
    step(); chk("jr_user_blk", Inst_addr, 32'h0000_1000);
    PCSrc = 3'd4;
    step(); chk("illop2", Inst_addr, 32'h8000_0004);
    PCSrc = 3'd3; PCout = 32'h8000_0100;
    step(); chk("jr_kern", Inst_addr, 32'h8000_0100);
    PCout = 32'h8000_1000;
    step(); chk("jr_kern2", Inst_addr, 32'h8000_1000);

    // user-space wrap of the sequential increment
    PCout = 32'h7FFF_FFFC;
    step(); chk("jr_7ffc", Inst_addr, 32'h7FFF_FFFC);
    PCSrc = 3'd0;
    step(); chk_all("wrap_user", 32'h0000_0000, 32'h0000_0000, I1, 1'b0);

    // jump keeps upper nibble 0 in user space
    PCSrc = 3'd2; JT = 26'h3FF_FFFF;
    step(); chk_all("jump_user", 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1);

    // kernel-space wrap keeps bit 31
    PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'hFFFF_FFFC;
    step(); chk("br_fffc", Inst_addr, 32'hFFFF_FFFC);
    PCSrc = 3'd0; IDcontrol_Branch = 1'b0;
    step(); chk_all("wrap_kern", 32'h8000_0000, 32'h8000_0000, I1, 1'b0);

    // PCSrc=6 behaves as sequential
    PCSrc = 3'd6;
    step(); chk_all("pcsrc6", 32'h8000_0004, 32'h8000_0004, I1, 1'b0);

    // reset in the middle of a stalled jump
    PCSrc = 3'd2; Stall = 1'b1; reset = 1'b1;
    step(); chk_all("rst_mid", 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; Stall = 1'b0; PCSrc = 3'd0;
    step(); chk_all("rst_rel", 32'h8000_0004, 32'h8000_0004, I1, 1'b0);

`ifdef IF_PERF_CNT_EN
    // counter: 5 fetches, 1 stall, 1 taken branch
    reset = 1'b1;
    step(); chk("cnt_clr", FetchCnt, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("cnt_5", FetchCnt, 32'd5);
    Stall = 1'b1;
    step();
    Stall = 1'b0; PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h8000_0040;
    step(); chk("cnt_final", FetchCnt, 32'd5);
    PCSrc = 3'd0; IDcontrol_Branch = 1'b0;
    step(); chk("cnt_6", FetchCnt, 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
